record_store: RTL and testbench
===============================

Name: record_store

Overview:
- Parametrised, handshaked record store that replaces the fixed 64-entry movie RAM with a generic ID-keyed table.
- Maintains a free-ID stack and a dense live-record list, so alloc, read, write, free and index-read each complete in one cycle.
- Clear is a multi-cycle sweep.
- Sits between the menu/control FSMs and the display or ticket logic; one instance per table (movies, sessions, orders).

Parameters:
- DEPTH, 64: table entries, power of two, >=4; ID 0 is reserved as NULL, so capacity is DEPTH-1.
- ID_W, $clog2(DEPTH): width of IDs, indices and count.
- DATA_W, 40: payload width per record.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  store can accept a command this cycle.
- cmd_op  in  3  000 NOP, 001 ALLOC, 010 READ_ID, 011 WRITE_ID, 100 FREE_ID, 101 READ_IDX, 111 CLEAR, 110 illegal.
- cmd_id  in  ID_W  target ID for READ_ID, WRITE_ID, FREE_ID.
- cmd_index  in  ID_W  0-based live-record index for READ_IDX.
- cmd_data  in  DATA_W  payload for ALLOC and WRITE_ID.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  2  00 OK, 01 ERR_FULL, 10 ERR_NOID, 11 ERR_OP.
- rsp_id  out  ID_W  result ID.
- rsp_data  out  DATA_W  read payload.
- count  out  ID_W  number of live records.
- full  out  1  count == DEPTH-1.
- empty  out  1  count == 0.

Behaviour:
Reset values:
- rst_n low asynchronously forces state IDLE.
- cmd_ready=1, rsp_valid=0, rsp_status=00, rsp_id=0, rsp_data=0, count=0, empty=1, full=0.
- The valid bitmap is all zero.
- The free stack is loaded so IDs pop in ascending order 1,2,...,DEPTH-1.
- Reset during a CLEAR sweep aborts it; the store ends in the full reset state.

Handshake:
- A command is accepted when cmd_valid && cmd_ready.
- cmd_ready = (state == IDLE).
- Inputs are sampled only on the accept edge.
- Single-cycle ops: accepted at edge N, rsp_valid=1 for exactly the cycle following edge N. cmd_ready stays high, so back-to-back commands give throughput 1/cycle.
- The table update is visible to a command accepted at edge N+1.
- count, full and empty update on the accept edge.
- An accepted NOP produces no response.

States:
- IDLE -> IDLE for every op except CLEAR.
- IDLE -> SWEEP on accepted CLEAR.
- SWEEP -> IDLE after the last entry.

Operations:
- ALLOC:
  - If full: status ERR_FULL, rsp_id=0, no change.
  - Otherwise pop the free stack, store cmd_data, set valid, append the ID at dense index count, count+1.
  - rsp_id = new ID.
- READ_ID: if cmd_id is valid, rsp_data = payload and rsp_id = cmd_id.
- WRITE_ID: if cmd_id is valid, overwrite the payload; the ID and dense position are unchanged; rsp_id = cmd_id.
- FREE_ID:
  - If cmd_id is valid, clear valid and push the ID onto the free stack; it becomes the next ID allocated (LIFO).
  - The last dense entry moves into the freed index; update its position entry; count-1.
- READ_IDX: if cmd_index < count, rsp_id = dense[cmd_index] and rsp_data = its payload.

Errors:
- cmd_id==0, or cmd_id not valid, gives ERR_NOID.
- cmd_index >= count gives ERR_NOID.
- Opcode 110 gives ERR_OP.
- Every error response has rsp_id=0, rsp_data=0 and makes no state change.
- Non-read OK responses have rsp_data=0.

CLEAR:
- Accepted at edge N: state SWEEP, cmd_ready=0.
- One entry is reinitialised per cycle for DEPTH cycles: valid=0, payload=0, free stack rebuilt in ascending pop order.
- count=0 from edge N+1.
- Final state is identical to reset.
- rsp_valid with status OK is asserted on the cycle SWEEP exits, i.e. DEPTH+1 cycles after accept.
- cmd_ready returns to 1 in that same cycle.

Arithmetic:
- Stack pointer and count are ID_W bits wide and never wrap.
- Overflow is blocked by the full check; underflow is impossible because FREE requires a valid ID.

Test Plan:
1. Reset, then ALLOC data=40'hA5 three times back-to-back -> responses on consecutive cycles with rsp_id 1,2,3, status 00; count=3.
2. From state 1: FREE_ID 2, then READ_IDX 1 -> rsp_id=3; READ_ID 2 -> ERR_NOID; next ALLOC returns rsp_id=2.
3. WRITE_ID 1 data=40'h123 then READ_ID 1 on the next cycle -> rsp_data=40'h123; READ_ID 0 -> ERR_NOID; opcode 110 -> ERR_OP.
4. Fill with 63 ALLOCs (DEPTH=64) -> full=1, 63rd rsp_id=63; 64th ALLOC -> ERR_FULL, count stays 63.
5. CLEAR with 5 live records -> cmd_ready low for 64 cycles, rsp OK 65 cycles after accept; then empty=1, READ_IDX 0 -> ERR_NOID, ALLOC -> rsp_id=1.
6. Assert rst_n low mid-SWEEP and mid-stream -> all outputs at reset values immediately; after release, ALLOC -> rsp_id=1. Repeat tests 1 and 4 at DEPTH=8, DATA_W=16.

Source files
------------

// File: rtl/record_store_if.sv
// rtl/record_store_if.sv - command/response bundle between a table client and record_store
interface record_store_if #(
    parameter int ID_W   = 6,
    parameter int DATA_W = 40
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ID_W-1:0]   cmd_id;
    logic [ID_W-1:0]   cmd_index;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [ID_W-1:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output cmd_valid, cmd_op, cmd_id, cmd_index, cmd_data,
        input  cmd_ready, rsp_valid, rsp_status, rsp_id, rsp_data, count, full, empty
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_id, cmd_index, cmd_data,
        output cmd_ready, rsp_valid, rsp_status, rsp_id, rsp_data, count, full, empty
    );
endinterface

// File: rtl/record_store.sv
// rtl/record_store.sv - ID-keyed record table with free-ID stack, dense live list and sweep clear
module record_store #(
    parameter int DEPTH  = 64,
    parameter int ID_W   = $clog2(DEPTH),
    parameter int DATA_W = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    record_store_if.slave bus
);
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_ALLOC    = 3'b001;
    localparam logic [2:0] OP_READ_ID  = 3'b010;
    localparam logic [2:0] OP_WRITE_ID = 3'b011;
    localparam logic [2:0] OP_FREE_ID  = 3'b100;
    localparam logic [2:0] OP_READ_IDX = 3'b101;
    localparam logic [2:0] OP_CLEAR    = 3'b111;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_FULL = 2'b01;
    localparam logic [1:0] ST_NOID = 2'b10;
    localparam logic [1:0] ST_OP   = 2'b11;

    localparam logic [ID_W-1:0] ID_LAST = ID_W'(DEPTH - 1);

    state_t            state;
    logic [ID_W-1:0]   count;
    logic [ID_W-1:0]   sweep_idx;
    logic [DEPTH-1:0]  valid;
    logic [DATA_W-1:0] payload  [DEPTH];
    logic [ID_W-1:0]   free_stk [DEPTH];
    logic [ID_W-1:0]   dense    [DEPTH];
    logic [ID_W-1:0]   pos      [DEPTH];

    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;

    // The free stack holds DEPTH-1-count entries, so its top is derived from count.
    logic              accept;
    logic              id_ok;
    logic              idx_ok;
    logic [ID_W-1:0]   pop_id;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   hole;

    assign accept  = bus.cmd_valid && (state == IDLE);
    assign id_ok   = valid[bus.cmd_id];
    assign idx_ok  = bus.cmd_index < count;
    assign pop_id  = free_stk[ID_W'(DEPTH - 2) - count];
    assign last_id = dense[count - ID_W'(1)];
    assign hole    = pos[bus.cmd_id];

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_status = rsp_status;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_data   = rsp_data;
    assign bus.count      = count;
    assign bus.full       = (count == ID_LAST);
    assign bus.empty      = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            sweep_idx  <= '0;
            valid      <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_id     <= '0;
            rsp_data   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload[i]  <= '0;
                free_stk[i] <= ID_W'(DEPTH - 1 - i);
                dense[i]    <= '0;
                pos[i]      <= '0;
            end
        end else begin
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_id     <= '0;
            rsp_data   <= '0;
            case (state)
                IDLE: if (accept) begin
                    rsp_valid <= (bus.cmd_op != OP_NOP);
                    case (bus.cmd_op)
                        OP_NOP: ;
                        OP_ALLOC: begin
                            if (count == ID_LAST) begin
                                rsp_status <= ST_FULL;
                            end else begin
                                payload[pop_id] <= bus.cmd_data;
                                valid[pop_id]   <= 1'b1;
                                dense[count]    <= pop_id;
                                pos[pop_id]     <= count;
                                count           <= count + ID_W'(1);
                                rsp_id          <= pop_id;
                            end
                        end
                        OP_READ_ID: begin
                            if (id_ok) begin
                                rsp_id   <= bus.cmd_id;
                                rsp_data <= payload[bus.cmd_id];
                            end else begin
                                rsp_status <= ST_NOID;
                            end
                        end
                        OP_WRITE_ID: begin
                            if (id_ok) begin
                                payload[bus.cmd_id] <= bus.cmd_data;
                                rsp_id              <= bus.cmd_id;
                            end else begin
                                rsp_status <= ST_NOID;
                            end
                        end
                        OP_FREE_ID: begin
                            // Last dense entry fills the hole; harmless when it is the freed ID itself.
                            if (id_ok) begin
                                valid[bus.cmd_id]        <= 1'b0;
                                free_stk[ID_LAST - count] <= bus.cmd_id;
                                dense[hole]              <= last_id;
                                pos[last_id]             <= hole;
                                count                    <= count - ID_W'(1);
                                rsp_id                   <= bus.cmd_id;
                            end else begin
                                rsp_status <= ST_NOID;
                            end
                        end
                        OP_READ_IDX: begin
                            if (idx_ok) begin
                                rsp_id   <= dense[bus.cmd_index];
                                rsp_data <= payload[dense[bus.cmd_index]];
                            end else begin
                                rsp_status <= ST_NOID;
                            end
                        end
                        OP_CLEAR: begin
                            state     <= SWEEP;
                            sweep_idx <= '0;
                            count     <= '0;
                            rsp_valid <= 1'b0;
                        end
                        default: rsp_status <= ST_OP;
                    endcase
                end
                SWEEP: begin
                    valid[sweep_idx]    <= 1'b0;
                    payload[sweep_idx]  <= '0;
                    free_stk[sweep_idx] <= ID_LAST - sweep_idx;
                    dense[sweep_idx]    <= '0;
                    pos[sweep_idx]      <= '0;
                    if (sweep_idx == ID_LAST) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                    end else begin
                        sweep_idx <= sweep_idx + ID_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_record_store.sv
// tb/tb_record_store.sv - directed self-checking bench for record_store at DEPTH 64 and DEPTH 8
module tb_record_store;
    localparam logic [2:0] NOP = 3'b000, ALLOC = 3'b001, RD_ID = 3'b010, WR_ID = 3'b011,
                           FREE = 3'b100, RD_IDX = 3'b101, BAD = 3'b110, CLEAR = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lowc;

    always #5 clk = ~clk;

    record_store_if #(.ID_W(6), .DATA_W(40)) b ();
    record_store_if #(.ID_W(3), .DATA_W(16)) bs ();

    record_store #(.DEPTH(64), .ID_W(6), .DATA_W(40)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    record_store #(.DEPTH(8), .ID_W(3), .DATA_W(16)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [5:0] id, input logic [5:0] idx,
                       input logic [39:0] data);
        b.cmd_valid = 1'b1; b.cmd_op = op; b.cmd_id = id; b.cmd_index = idx; b.cmd_data = data;
        @(negedge clk);
    endtask

    task automatic cmd_s(input logic [2:0] op, input logic [15:0] data);
        bs.cmd_valid = 1'b1; bs.cmd_op = op; bs.cmd_id = '0; bs.cmd_index = '0; bs.cmd_data = data;
        @(negedge clk);
    endtask

    task automatic idle();
        b.cmd_valid = 1'b0; b.cmd_op = NOP;
        bs.cmd_valid = 1'b0; bs.cmd_op = NOP;
    endtask

    task automatic rsp(input string tag, input logic [1:0] st, input logic [5:0] id, input logic [39:0] data);
        check({tag, ".valid"}, b.rsp_valid, 1);
        check({tag, ".status"}, b.rsp_status, st);
        check({tag, ".id"}, b.rsp_id, id);
        check({tag, ".data"}, b.rsp_data, data);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        b.cmd_id = '0; b.cmd_index = '0; b.cmd_data = '0;
        bs.cmd_id = '0; bs.cmd_index = '0; bs.cmd_data = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", b.cmd_ready, 1);
        check("rst.rsp_valid", b.rsp_valid, 0);
        check("rst.status", b.rsp_status, 0);
        check("rst.id", b.rsp_id, 0);
        check("rst.data", b.rsp_data, 0);
        check("rst.count", b.count, 0);
        check("rst.empty", b.empty, 1);
        check("rst.full", b.full, 0);
        rst_n = 1'b1;

        // Three back-to-back allocations
        cmd(ALLOC, 0, 0, 40'hA5); rsp("alloc1", 2'b00, 1, 0);
        cmd(ALLOC, 0, 0, 40'hA5); rsp("alloc2", 2'b00, 2, 0);
        cmd(ALLOC, 0, 0, 40'hA5); rsp("alloc3", 2'b00, 3, 0);
        check("alloc.count", b.count, 3);

        // Free from the middle: last dense entry (ID 3) moves to index 1
        cmd(FREE, 2, 0, 0);        rsp("free2", 2'b00, 2, 0);
        check("free2.count", b.count, 2);
        cmd(RD_IDX, 0, 1, 0);      rsp("rdidx1", 2'b00, 3, 40'hA5);
        cmd(RD_ID, 2, 0, 0);       rsp("rdid_freed", 2'b10, 0, 0);
        cmd(ALLOC, 0, 0, 40'h77);  rsp("realloc", 2'b00, 2, 0);
        check("realloc.count", b.count, 3);

        cmd(WR_ID, 1, 0, 40'h123); rsp("write1", 2'b00, 1, 0);
        cmd(RD_ID, 1, 0, 0);       rsp("read1", 2'b00, 1, 40'h123);
        cmd(RD_ID, 0, 0, 0);       rsp("read0", 2'b10, 0, 0);
        cmd(BAD, 1, 0, 40'h5);     rsp("badop", 2'b11, 0, 0);
        cmd(WR_ID, 5, 0, 40'h9);   rsp("write_noid", 2'b10, 0, 0);
        cmd(NOP, 0, 0, 0);
        check("nop.rsp_valid", b.rsp_valid, 0);
        cmd(RD_IDX, 0, 2, 0);      rsp("rdidx2", 2'b00, 2, 40'h77);
        cmd(RD_IDX, 0, 3, 0);      rsp("rdidx_oob", 2'b10, 0, 0);
        idle();

        // Fill to capacity
        do_reset();
        for (int i = 0; i < 63; i++) begin
            cmd(ALLOC, 0, 0, 40'(i));
            check("fill.id", b.rsp_id, 64'(i + 1));
        end
        check("fill.full", b.full, 1);
        check("fill.count", b.count, 63);
        cmd(ALLOC, 0, 0, 40'hFF);  rsp("overfill", 2'b01, 0, 0);
        check("overfill.count", b.count, 63);
        cmd(RD_IDX, 0, 62, 0);     rsp("rdidx62", 2'b00, 63, 40'd62);
        cmd(RD_IDX, 0, 63, 0);     rsp("rdidx63", 2'b10, 0, 0);
        idle();

        // CLEAR with five live records
        do_reset();
        for (int i = 0; i < 5; i++) cmd(ALLOC, 0, 0, 40'h10 + 40'(i));
        cmd(CLEAR, 0, 0, 0);
        idle();
        check("clear.count", b.count, 0);
        check("clear.rsp_early", b.rsp_valid, 0);
        lowc = 0;
        while (b.cmd_ready === 1'b0 && lowc < 200) begin
            lowc++;
            @(negedge clk);
        end
        check("clear.busy_cycles", 64'(lowc), 64);
        check("clear.rsp_valid", b.rsp_valid, 1);
        check("clear.rsp_status", b.rsp_status, 0);
        check("clear.empty", b.empty, 1);
        cmd(RD_IDX, 0, 0, 0);      rsp("clear.rdidx0", 2'b10, 0, 0);
        cmd(RD_ID, 3, 0, 0);       rsp("clear.rdid3", 2'b10, 0, 0);
        cmd(ALLOC, 0, 0, 40'h1);   rsp("clear.alloc", 2'b00, 1, 0);
        idle();

        // Reset in the middle of a sweep
        cmd(ALLOC, 0, 0, 40'h2);
        cmd(CLEAR, 0, 0, 0);
        idle();
        repeat (10) @(negedge clk);
        check("sweep.ready_low", b.cmd_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("sweep_rst.ready", b.cmd_ready, 1);
        check("sweep_rst.rsp_valid", b.rsp_valid, 0);
        check("sweep_rst.count", b.count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(ALLOC, 0, 0, 40'h3);   rsp("sweep_rst.alloc", 2'b00, 1, 0);
        cmd(RD_IDX, 0, 0, 0);      rsp("sweep_rst.rdidx", 2'b00, 1, 40'h3);

        // Reset in the middle of a command stream
        cmd(ALLOC, 0, 0, 40'h4);
        b.cmd_valid = 1'b1; b.cmd_op = ALLOC;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("stream_rst.rsp_valid", b.rsp_valid, 0);
        check("stream_rst.rsp_id", b.rsp_id, 0);
        check("stream_rst.count", b.count, 0);
        check("stream_rst.empty", b.empty, 1);
        check("stream_rst.ready", b.cmd_ready, 1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        cmd(ALLOC, 0, 0, 40'h5);   rsp("stream_rst.alloc", 2'b00, 1, 0);
        idle();

        // Small instance: DEPTH 8, DATA_W 16
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_s(ALLOC, 16'hA5);
            check("s.alloc.valid", bs.rsp_valid, 1);
            check("s.alloc.id", bs.rsp_id, 64'(i + 1));
        end
        check("s.alloc.count", bs.count, 3);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cmd_s(ALLOC, 16'(i));
            check("s.fill.id", bs.rsp_id, 64'(i + 1));
        end
        check("s.fill.full", bs.full, 1);
        check("s.fill.count", bs.count, 7);
        cmd_s(ALLOC, 16'hFF);
        check("s.overfill.valid", bs.rsp_valid, 1);
        check("s.overfill.status", bs.rsp_status, 1);
        check("s.overfill.id", bs.rsp_id, 0);
        check("s.overfill.count", bs.count, 7);
        idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
